// File: rtl/rr_arbiter_requester.sv
// ---------------------------------------------------------------------------
// rr_arbiter_requester
//   Requester-side bank for a round-robin arbiter. Each client hands over a
//   burst length; the bank raises REQ for that client and holds it until the
//   arbiter has granted that many beats. A grant may be revoked mid-burst
//   (time slice expired); the client then goes back to waiting with REQ still
//   high and keeps the beats already counted.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous assert, active-low reset
//   cmd_valid  in   [N_CLIENTS]        per-client burst command valid
//   cmd_len    in   [N_CLIENTS*LEN_W]  per-client burst length (client i at i*LEN_W)
//   cmd_ready  out  [N_CLIENTS]        command accept, high only while client is idle
//   REQ        out  [N_CLIENTS]        registered request to the arbiter
//   GNT        in   [N_CLIENTS]        grant from the arbiter, one-hot or zero
//   beat       out  [N_CLIENTS]        REQ & GNT, one beat transferred this cycle
//   done       out  [N_CLIENTS]        registered one-cycle pulse when a burst ends
//   starve     out  [N_CLIENTS]        sticky: waited WAIT_MAX cycles without grant
//   grant_err  out                     sticky: multi-hot GNT or grant without request
// ---------------------------------------------------------------------------
module rr_arbiter_requester #(
    parameter int N_CLIENTS = 4,
    parameter int LEN_W     = 4,
    parameter int WAIT_MAX  = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CLIENTS-1:0]         cmd_valid,
    input  logic [N_CLIENTS*LEN_W-1:0]   cmd_len,
    output logic [N_CLIENTS-1:0]         cmd_ready,
    output logic [N_CLIENTS-1:0]         REQ,
    input  logic [N_CLIENTS-1:0]         GNT,
    output logic [N_CLIENTS-1:0]         beat,
    output logic [N_CLIENTS-1:0]         done,
    output logic [N_CLIENTS-1:0]         starve,
    output logic                         grant_err
);

    localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t             state_q [N_CLIENTS];
    state_t             state_d [N_CLIENTS];
    logic [LEN_W-1:0]   rem_q   [N_CLIENTS];
    logic [LEN_W-1:0]   rem_d   [N_CLIENTS];
    logic [WAIT_W-1:0]  wait_q  [N_CLIENTS];
    logic [WAIT_W-1:0]  wait_d  [N_CLIENTS];

    logic [N_CLIENTS-1:0] req_d;
    logic [N_CLIENTS-1:0] done_d;
    logic [N_CLIENTS-1:0] starve_d;
    logic                 grant_err_d;
    logic                 gnt_multi;
    logic                 gnt_stray;

    // A beat only exists where we are actually requesting; stray grants never count.
    assign beat = REQ & GNT;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign gnt_multi = (GNT & (GNT - N_CLIENTS'(1))) != '0;
    assign gnt_stray = (GNT & ~REQ) != '0;

    always_comb begin
        grant_err_d = grant_err | gnt_multi | gnt_stray;
        req_d       = '0;
        done_d      = '0;
        starve_d    = starve;
        cmd_ready   = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            state_d[i]   = state_q[i];
            rem_d[i]     = rem_q[i];
            wait_d[i]    = wait_q[i];
            cmd_ready[i] = (state_q[i] == IDLE);

            case (state_q[i])
                IDLE: begin
                    if (cmd_valid[i]) begin
                        if (cmd_len[i*LEN_W +: LEN_W] != '0) begin
                            rem_d[i]   = cmd_len[i*LEN_W +: LEN_W];
                            wait_d[i]  = '0;
                            state_d[i] = WAIT;
                        end else begin
                            // Zero-length burst completes without ever requesting.
                            done_d[i] = 1'b1;
                        end
                    end
                end
                WAIT, XFER: begin
                    if (GNT[i]) begin
                        rem_d[i] = rem_q[i] - LEN_W'(1);
                        if (rem_q[i] == LEN_W'(1)) begin
                            state_d[i] = IDLE;
                            done_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = XFER;
                        end
                    end else if (state_q[i] == XFER) begin
                        // Slice revoked: keep requesting, restart the starvation window.
                        state_d[i] = WAIT;
                        wait_d[i]  = '0;
                    end else if (wait_q[i] != WAIT_LIM) begin
                        wait_d[i] = wait_q[i] + WAIT_W'(1);
                        if (wait_d[i] >= WAIT_LIM) begin
                            starve_d[i] = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase

            req_d[i] = (state_d[i] != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                state_q[i] <= IDLE;
                rem_q[i]   <= '0;
                wait_q[i]  <= '0;
            end
            REQ       <= '0;
            done      <= '0;
            starve    <= '0;
            grant_err <= 1'b0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
                wait_q[i]  <= wait_d[i];
            end
            REQ       <= req_d;
            done      <= done_d;
            starve    <= starve_d;
            grant_err <= grant_err_d;
        end
    end

endmodule
